pwr_seq_ctrl: RTL and testbench

//  Parametrised multi-domain power sequencer: drives power-switch enable, isolation, domain reset and

---
 rtl/pwr_seq_pkg.sv | 51 +++++
 rtl/pwr_seq_ctrl_if.sv | 26 ++
 rtl/pwr_dom_fsm.sv | 115 +++++++++++
 rtl/pwr_seq_ctrl.sv | 81 ++++++++
 tb/tb_pwr_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared types for the power sequencer: domain FSM states, per-domain control bundle, helpers.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_SW_ON,
    ST_RST_REL,
    ST_RESTORE,
    ST_ISO_REL,
    ST_ON,
    ST_SAVE,
    ST_ISO_SET,
    ST_SW_OFF,
    ST_ERR
  } pwr_state_e;

  typedef struct packed {
    logic sw_en;
    logic iso_en;
    logic dom_rst_n;
    logic save;
    logic restore;
    logic dom_on;
    logic err;
  } dom_ctl_t;

  localparam dom_ctl_t CTL_RST = '{sw_en: 1'b0, iso_en: 1'b1, dom_rst_n: 1'b0, save: 1'b0,
                                   restore: 1'b0, dom_on: 1'b0, err: 1'b0};

  function automatic logic is_transitional(pwr_state_e s);
    return !(s inside {ST_OFF, ST_ON, ST_ERR});
  endfunction

  // Counter load so a timed state lasts exactly d cycles (0 behaves as 1).
  function automatic int unsigned dly_load(int unsigned d);
    return (d == 0) ? 0 : d - 1;
  endfunction

  // Level outputs implied by a state; retention pulses are added by the FSM on state entry.
  function automatic dom_ctl_t ctl_decode(pwr_state_e s);
    dom_ctl_t c;
    c           = CTL_RST;
    c.sw_en     = s inside {ST_SW_ON, ST_RST_REL, ST_RESTORE, ST_ISO_REL, ST_ON, ST_SAVE, ST_ISO_SET};
    c.iso_en    = !(s inside {ST_ON, ST_SAVE});
    c.dom_rst_n = s inside {ST_RESTORE, ST_ISO_REL, ST_ON, ST_SAVE, ST_ISO_SET};
    c.dom_on    = (s == ST_ON);
    c.err       = (s == ST_ERR);
    return c;
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// PMU-to-sequencer bundle: per-domain requests/acks in, switch/isolation/reset controls out.
interface pwr_seq_ctrl_if #(
  parameter int unsigned NUM_DOM = 2
);
  logic [NUM_DOM-1:0] pwr_req;
  logic [NUM_DOM-1:0] pwr_ack;
  logic [NUM_DOM-1:0] err_clr;
  logic [NUM_DOM-1:0] sw_en;
  logic [NUM_DOM-1:0] iso_en;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic [NUM_DOM-1:0] save;
  logic [NUM_DOM-1:0] restore;
  logic [NUM_DOM-1:0] dom_on;
  logic [NUM_DOM-1:0] err;
  logic               busy;

  modport master (
    output pwr_req, pwr_ack, err_clr,
    input  sw_en, iso_en, dom_rst_n, save, restore, dom_on, err, busy
  );

  modport slave (
    input  pwr_req, pwr_ack, err_clr,
    output sw_en, iso_en, dom_rst_n, save, restore, dom_on, err, busy
  );
endinterface

// File: rtl/pwr_dom_fsm.sv
// One switchable domain: ack synchroniser, delay/timeout counter and the up/down sequence FSM.
module pwr_dom_fsm
  import pwr_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ISO_DLY     = 4,
  parameter int unsigned RST_DLY     = 4,
  parameter int unsigned RET_DLY     = 2,
  parameter int unsigned ACK_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req_i,
  input  logic       pwr_ack_i,
  input  logic       err_clr_i,
  input  logic       grant_i,
  output pwr_state_e state_o,
  output dom_ctl_t   ctl_o
);

  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(dly_load(ISO_DLY));
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(dly_load(RST_DLY));
  localparam logic [CNT_W-1:0] RET_LD = CNT_W'(dly_load(RET_DLY));
  localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT);

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_meta_q, ack_sync_q;
  dom_ctl_t         ctl_q, ctl_d;
  logic             cnt_zero_c;

  assign cnt_zero_c = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
      ctl_q      <= CTL_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_meta_q <= pwr_ack_i;
      ack_sync_q <= ack_meta_q;
      ctl_q      <= ctl_d;
    end
  end

  // Timed states exit when the counter hits zero; ack waits exit on target level or time out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: if (pwr_req_i && grant_i) begin
        state_d = ST_SW_ON;
        cnt_d   = ACK_LD;
      end
      ST_SW_ON: begin
        if (ack_sync_q) begin
          state_d = ST_RST_REL;
          cnt_d   = RST_LD;
        end else if (cnt_zero_c) state_d = ST_ERR;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RST_REL: begin
        if (cnt_zero_c) begin
          state_d = ST_RESTORE;
          cnt_d   = RET_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RESTORE: begin
        if (cnt_zero_c) begin
          state_d = ST_ISO_REL;
          cnt_d   = ISO_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ISO_REL: begin
        if (cnt_zero_c) state_d = ST_ON;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ON: if (!pwr_req_i && grant_i) begin
        state_d = ST_SAVE;
        cnt_d   = RET_LD;
      end
      ST_SAVE: begin
        if (cnt_zero_c) begin
          state_d = ST_ISO_SET;
          cnt_d   = ISO_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ISO_SET: begin
        if (cnt_zero_c) begin
          state_d = ST_SW_OFF;
          cnt_d   = ACK_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_SW_OFF: begin
        if (!ack_sync_q) state_d = ST_OFF;
        else if (cnt_zero_c) state_d = ST_ERR;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ERR: if (err_clr_i) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase

    ctl_d         = ctl_decode(state_d);
    ctl_d.save    = (state_d == ST_SAVE) && (state_q != ST_SAVE);
    ctl_d.restore = (state_d == ST_RESTORE) && (state_q != ST_RESTORE);
  end

  assign state_o = state_q;
  assign ctl_o   = ctl_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Multi-domain power sequencer: per-domain FSMs plus lowest-index-first serialising grant.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM     = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ISO_DLY     = 4,
  parameter int unsigned RST_DLY     = 4,
  parameter int unsigned RET_DLY     = 2,
  parameter int unsigned ACK_TIMEOUT = 200,
  parameter int unsigned SERIAL      = 1
) (
  input logic           clk,
  input logic           rst_n,
  pwr_seq_ctrl_if.slave bus
);

  pwr_state_e         state [NUM_DOM];
  dom_ctl_t           ctl   [NUM_DOM];
  logic [NUM_DOM-1:0] trans_c, pend_c, grant_c;
  logic [NUM_DOM-1:0] sw_en_c, iso_en_c, dom_rst_n_c, save_c, restore_c, dom_on_c, err_c;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    pwr_dom_fsm #(
      .CNT_W      (CNT_W),
      .ISO_DLY    (ISO_DLY),
      .RST_DLY    (RST_DLY),
      .RET_DLY    (RET_DLY),
      .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwr_req_i(bus.pwr_req[g]),
      .pwr_ack_i(bus.pwr_ack[g]),
      .err_clr_i(bus.err_clr[g]),
      .grant_i  (grant_c[g]),
      .state_o  (state[g]),
      .ctl_o    (ctl[g])
    );

    assign trans_c[g] = is_transitional(state[g]);
    assign pend_c[g]  = ((state[g] == ST_OFF) && bus.pwr_req[g]) ||
                        ((state[g] == ST_ON)  && !bus.pwr_req[g]);
  end

  // Grant only while nothing is in flight; pend & -pend isolates the lowest pending domain.
  always_comb begin
    grant_c = '0;
    if (SERIAL == 0) grant_c = '1;
    else if (trans_c == '0) grant_c = pend_c & (~pend_c + NUM_DOM'(1));
  end

  always_comb begin
    sw_en_c     = '0;
    iso_en_c    = '0;
    dom_rst_n_c = '0;
    save_c      = '0;
    restore_c   = '0;
    dom_on_c    = '0;
    err_c       = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      sw_en_c[i]     = ctl[i].sw_en;
      iso_en_c[i]    = ctl[i].iso_en;
      dom_rst_n_c[i] = ctl[i].dom_rst_n;
      save_c[i]      = ctl[i].save;
      restore_c[i]   = ctl[i].restore;
      dom_on_c[i]    = ctl[i].dom_on;
      err_c[i]       = ctl[i].err;
    end
  end

  assign bus.sw_en     = sw_en_c;
  assign bus.iso_en    = iso_en_c;
  assign bus.dom_rst_n = dom_rst_n_c;
  assign bus.save      = save_c;
  assign bus.restore   = restore_c;
  assign bus.dom_on    = dom_on_c;
  assign bus.err       = err_c;
  assign bus.busy      = |trans_c;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench: a 2-domain serial sequencer and a 4-domain independent one, with a switch model.
module tb_pwr_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pwr_seq_ctrl_if #(.NUM_DOM(2)) bs ();
  pwr_seq_ctrl_if #(.NUM_DOM(4)) bp ();

  pwr_seq_ctrl #(.NUM_DOM(2), .SERIAL(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  pwr_seq_ctrl #(.NUM_DOM(4), .SERIAL(0)) u_dut_p (.clk(clk), .rst_n(rst_n), .bus(bp));

  // Power switch model: ack follows sw_en after 10 cycles unless the switch is marked dead.
  logic [1:0] live_s;
  logic [3:0] live_p;
  logic [3:0] dly_s [2];
  logic [3:0] dly_p [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs.pwr_ack <= '0;
      for (int i = 0; i < 2; i++) dly_s[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (live_s[i] && (bs.sw_en[i] != bs.pwr_ack[i])) begin
          if (dly_s[i] == 4'd9) begin
            bs.pwr_ack[i] <= bs.sw_en[i];
            dly_s[i]      <= '0;
          end else dly_s[i] <= dly_s[i] + 4'd1;
        end else dly_s[i] <= '0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp.pwr_ack <= '0;
      for (int i = 0; i < 4; i++) dly_p[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (live_p[i] && (bp.sw_en[i] != bp.pwr_ack[i])) begin
          if (dly_p[i] == 4'd9) begin
            bp.pwr_ack[i] <= bp.sw_en[i];
            dly_p[i]      <= '0;
          end else dly_p[i] <= dly_p[i] + 4'd1;
        end else dly_p[i] <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bs.pwr_req = '0;
    bs.err_clr = '0;
    bp.pwr_req = '0;
    bp.err_clr = '0;
    live_s     = '1;
    live_p     = '1;
    step(2);
    rst_n = 1'b1;
  endtask

  int start_p [4];

  initial begin
    rst_n      = 1'b0;
    bs.pwr_req = '0;
    bs.err_clr = '0;
    bp.pwr_req = '0;
    bp.err_clr = '0;
    live_s     = '1;
    live_p     = '1;
    step(2);
    chk("rst sw_en",   32'(bs.sw_en), 0);
    chk("rst iso_en",  32'(bs.iso_en), 3);
    chk("rst dom_rst", 32'(bs.dom_rst_n), 0);
    chk("rst save",    32'(bs.save), 0);
    chk("rst restore", 32'(bs.restore), 0);
    chk("rst dom_on",  32'(bs.dom_on), 0);
    chk("rst busy",    32'(bs.busy), 0);
    chk("rst err",     32'(bs.err), 0);
    chk("rst p iso",   32'(bp.iso_en), 15);

    // Single domain full up/down sequence
    do_reset();
    bs.pwr_req = 2'b01;
    step(1);
    chk("s1 sw_en rise", 32'(bs.sw_en), 1);
    chk("s1 busy",       32'(bs.busy), 1);
    step(12);
    chk("s1 rst held 13", 32'(bs.dom_rst_n), 0);
    step(4);
    chk("s1 rst held 17", 32'(bs.dom_rst_n), 0);
    step(1);
    chk("s1 rst rel",     32'(bs.dom_rst_n), 1);
    chk("s1 restore",     32'(bs.restore), 1);
    step(1);
    chk("s1 restore end", 32'(bs.restore), 0);
    step(4);
    chk("s1 iso 23",      32'(bs.iso_en), 3);
    chk("s1 dom_on 23",   32'(bs.dom_on), 0);
    step(1);
    chk("s1 iso rel",     32'(bs.iso_en), 2);
    chk("s1 dom_on",      32'(bs.dom_on), 1);
    chk("s1 idle busy",   32'(bs.busy), 0);
    bs.pwr_req = 2'b00;
    step(1);
    chk("s1 save",        32'(bs.save), 1);
    chk("s1 dom_on off",  32'(bs.dom_on), 0);
    step(1);
    chk("s1 save end",    32'(bs.save), 0);
    step(1);
    chk("s1 iso set",     32'(bs.iso_en), 3);
    step(3);
    chk("s1 sw_en held",  32'(bs.sw_en), 1);
    step(1);
    chk("s1 sw_en fall",  32'(bs.sw_en), 0);
    chk("s1 rst assert",  32'(bs.dom_rst_n), 0);
    step(12);
    chk("s1 wait ack0",   32'(bs.busy), 1);
    step(1);
    chk("s1 off",         32'(bs.busy), 0);

    // Simultaneous requests, serialised lower index first
    do_reset();
    bs.pwr_req = 2'b11;
    step(1);
    chk("s2 d0 first",    32'(bs.sw_en), 1);
    step(11);
    chk("s2 busy mid",    32'(bs.busy), 1);
    chk("s2 d1 waits",    32'(bs.sw_en), 1);
    step(12);
    chk("s2 d0 on",       32'(bs.dom_on), 1);
    chk("s2 d1 still",    32'(bs.sw_en), 1);
    step(1);
    chk("s2 d1 sw_en",    32'(bs.sw_en), 3);
    chk("s2 busy d1",     32'(bs.busy), 1);
    step(22);
    chk("s2 d1 not on",   32'(bs.dom_on), 1);
    chk("s2 busy 47",     32'(bs.busy), 1);
    step(1);
    chk("s2 both on",     32'(bs.dom_on), 3);
    chk("s2 iso rel",     32'(bs.iso_en), 0);
    chk("s2 busy end",    32'(bs.busy), 0);

    // Ack never arrives: timeout, error clear, re-power
    do_reset();
    live_s     = 2'b10;
    bs.pwr_req = 2'b01;
    step(1);
    chk("s3 sw_en",       32'(bs.sw_en), 1);
    step(200);
    chk("s3 no err 201",  32'(bs.err), 0);
    chk("s3 sw_en 201",   32'(bs.sw_en), 1);
    step(1);
    chk("s3 err",         32'(bs.err), 1);
    chk("s3 err sw_en",   32'(bs.sw_en), 0);
    chk("s3 err iso",     32'(bs.iso_en), 3);
    chk("s3 err rst",     32'(bs.dom_rst_n), 0);
    chk("s3 err busy",    32'(bs.busy), 0);
    bs.err_clr = 2'b10;
    step(1);
    bs.err_clr = 2'b00;
    step(2);
    chk("s3 err sticky",  32'(bs.err), 1);
    bs.err_clr = 2'b01;
    step(1);
    bs.err_clr = 2'b00;
    chk("s3 err cleared", 32'(bs.err), 0);
    chk("s3 off",         32'(bs.sw_en), 0);
    step(1);
    chk("s3 repower",     32'(bs.sw_en), 1);
    chk("s3 repower busy", 32'(bs.busy), 1);

    // Request withdrawn mid power-up: completes, then powers down
    do_reset();
    bs.pwr_req = 2'b01;
    step(15);
    chk("s4 in rst_rel",  32'(bs.dom_rst_n), 0);
    chk("s4 sw_en",       32'(bs.sw_en), 1);
    bs.pwr_req = 2'b00;
    step(9);
    chk("s4 reaches on",  32'(bs.dom_on), 1);
    step(1);
    chk("s4 save",        32'(bs.save), 1);
    chk("s4 on left",     32'(bs.dom_on), 0);
    step(1);
    chk("s4 no reentry",  32'(bs.dom_on), 0);
    step(1);
    chk("s4 iso set",     32'(bs.iso_en), 3);
    step(3);
    chk("s4 sw_en held",  32'(bs.sw_en), 1);
    step(1);
    chk("s4 sw_en fall",  32'(bs.sw_en), 0);
    step(12);
    chk("s4 busy 43",     32'(bs.busy), 1);
    step(1);
    chk("s4 off",         32'(bs.busy), 0);
    step(2);
    chk("s4 stays off",   32'(bs.sw_en), 0);

    // Asynchronous reset during SAVE
    do_reset();
    bs.pwr_req = 2'b01;
    step(24);
    chk("s5 on",          32'(bs.dom_on), 1);
    bs.pwr_req = 2'b00;
    step(1);
    chk("s5 in save",     32'(bs.save), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5 sw_en",       32'(bs.sw_en), 0);
    chk("s5 iso_en",      32'(bs.iso_en), 3);
    chk("s5 dom_rst",     32'(bs.dom_rst_n), 0);
    chk("s5 save",        32'(bs.save), 0);
    chk("s5 busy",        32'(bs.busy), 0);

    // Independent domains, staggered requests
    do_reset();
    start_p = '{0, 2, 5, 9};
    for (int c = 1; c <= 34; c++) begin
      for (int i = 0; i < 4; i++) if (start_p[i] == c - 1) bp.pwr_req[i] = 1'b1;
      step(1);
      for (int i = 0; i < 4; i++) begin
        if (c == start_p[i] + 1)  chk($sformatf("s6 d%0d sw_en", i), 32'(bp.sw_en[i]), 1);
        if (c == start_p[i] + 23) chk($sformatf("s6 d%0d pre on", i), 32'(bp.dom_on[i]), 0);
        if (c == start_p[i] + 24) begin
          chk($sformatf("s6 d%0d on", i),  32'(bp.dom_on[i]), 1);
          chk($sformatf("s6 d%0d iso", i), 32'(bp.iso_en[i]), 0);
        end
      end
      if (c == 10) chk("s6 overlap", 32'(bp.sw_en), 15);
      if (c == 20) chk("s6 busy",    32'(bp.busy), 1);
      if (c == 33) chk("s6 all on",  32'(bp.dom_on), 15);
      if (c == 33) chk("s6 idle",    32'(bp.busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
